// File: rtl/ram_rd_dc_pkg.sv
// Shared types, default widths and the address classifier for the RAM/IO
// read decoder (ram_rd_dc).
package ram_dc_pkg;

  // Where a read address lands in the data map
  typedef enum logic [1:0] {
    AD_RAM  = 2'd0,
    AD_IO   = 2'd1,
    AD_MISS = 2'd2
  } ad_class_e;

  // Default geometry of the data map
  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_IO_BASE   = 65;
  localparam int unsigned DEF_RAM_DEPTH = 8;
  localparam int unsigned DEF_IO_NUM    = 2;
  localparam int unsigned DEF_MISS_W    = 8;

  // Classify an address. The IO window test checks a >= io_base before
  // subtracting, so an address below the window can never underflow into it.
  function automatic ad_class_e addr_class(input int unsigned a,
                                           input int unsigned ram_depth,
                                           input int unsigned io_base,
                                           input int unsigned io_num);
    ad_class_e cls;
    cls = AD_MISS;
    if (a < ram_depth) begin
      cls = AD_RAM;
    end else if ((a >= io_base) && ((a - io_base) < io_num)) begin
      cls = AD_IO;
    end
    return cls;
  endfunction

endpackage

// File: rtl/ram_rd_dc_if.sv
// Request/response bundle between the CPU data path (master) and the
// RAM/IO read decoder (slave).
interface ram_rd_dc_if
  import ram_dc_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int unsigned IO_NUM    = DEF_IO_NUM,
  parameter int unsigned MISS_W    = DEF_MISS_W
);

  logic                        RD_REQ;
  logic [ADDR_W-1:0]           RAM_AD_IN;
  logic [RAM_DEPTH*DATA_W-1:0] RAM_FLAT;
  logic [IO_NUM*DATA_W-1:0]    IO_IN;
  logic                        MISS_CLR;

  logic [ADDR_W-1:0]           RAM_AD_OUT;
  logic [DATA_W-1:0]           RAM_OUT;
  logic                        RD_VALID;
  logic                        RD_MISS;
  logic [MISS_W-1:0]           MISS_CNT;

  // Data path side: issues requests, supplies RAM/IO contents, sees results
  modport master (
    output RD_REQ, RAM_AD_IN, RAM_FLAT, IO_IN, MISS_CLR,
    input  RAM_AD_OUT, RAM_OUT, RD_VALID, RD_MISS, MISS_CNT
  );

  // Decoder side
  modport slave (
    input  RD_REQ, RAM_AD_IN, RAM_FLAT, IO_IN, MISS_CLR,
    output RAM_AD_OUT, RAM_OUT, RD_VALID, RD_MISS, MISS_CNT
  );

endinterface

// File: rtl/ram_rd_dc_io_sync.sv
// Two-flop synchronizer for one input-port word. Only built when
// RAM_RD_DC_IO_SYNC_EN is defined; otherwise the ports are read directly
// and this module does not exist.
`ifdef RAM_RD_DC_IO_SYNC_EN
module io_sync #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_q, meta_d;
  logic [DATA_W-1:0] sync_q, sync_d;

  // Each stage simply takes the previous one
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer chain, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`endif

// File: rtl/ram_rd_dc.sv
// Registered read decoder: returns one word from the RAM bank or an input
// port one clock after RD_REQ, flags unmapped addresses and counts them in a
// saturating counter.
// Macro RAM_RD_DC_IO_SYNC_EN: when defined, each input port passes through a
// two-flop synchronizer before the decode mux.
module ram_rd_dc
  import ram_dc_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int unsigned IO_NUM    = DEF_IO_NUM,
  parameter int unsigned IO_BASE   = DEF_IO_BASE,
  parameter int unsigned MISS_W    = DEF_MISS_W
) (
  input  logic       CLK_DC,
  input  logic       RESET,
  ram_rd_dc_if.slave bus
);

  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);
  localparam logic [MISS_W-1:0] CNT_MAX   = '1;

  // Reject maps that overlap or do not fit in the address space
  if (RAM_DEPTH < 1) begin : g_err_depth
    $error("ram_rd_dc: RAM_DEPTH must be at least 1");
  end
  if (IO_NUM < 1) begin : g_err_io_num
    $error("ram_rd_dc: IO_NUM must be at least 1");
  end
  if (RAM_DEPTH > IO_BASE) begin : g_err_overlap
    $error("ram_rd_dc: RAM window overlaps the IO window");
  end
  if ((64'(IO_BASE) + 64'(IO_NUM)) > (64'd1 << ADDR_W)) begin : g_err_io_range
    $error("ram_rd_dc: IO window exceeds the address space");
  end

  // Port values as seen by the decode mux
  logic [DATA_W-1:0] io_src [IO_NUM];

`ifdef RAM_RD_DC_IO_SYNC_EN
  for (genvar j = 0; j < IO_NUM; j++) begin : g_io_sync
    io_sync #(
      .DATA_W(DATA_W)
    ) u_io_sync (
      .clk(CLK_DC),
      .rst(RESET),
      .d  (bus.IO_IN[j*DATA_W +: DATA_W]),
      .q  (io_src[j])
    );
  end
`else
  for (genvar j = 0; j < IO_NUM; j++) begin : g_io_direct
    assign io_src[j] = bus.IO_IN[j*DATA_W +: DATA_W];
  end
`endif

  ad_class_e         ad_cls;
  logic [ADDR_W-1:0] io_off;
  logic [DATA_W-1:0] ram_word;
  logic [DATA_W-1:0] io_word;

  // Address decode: classify the address and pre-select the RAM and IO words
  always_comb begin
    ad_cls   = addr_class(32'(bus.RAM_AD_IN), RAM_DEPTH, IO_BASE, IO_NUM);
    io_off   = bus.RAM_AD_IN - IO_BASE_A;
    ram_word = '0;
    io_word  = '0;
    for (int i = 0; i < RAM_DEPTH; i++) begin
      if (bus.RAM_AD_IN == ADDR_W'(i)) begin
        ram_word = bus.RAM_FLAT[i*DATA_W +: DATA_W];
      end
    end
    for (int j = 0; j < IO_NUM; j++) begin
      if (io_off == ADDR_W'(j)) begin
        io_word = io_src[j];
      end
    end
  end

  logic [ADDR_W-1:0] ram_ad_out_q, ram_ad_out_d;
  logic [DATA_W-1:0] ram_out_q,    ram_out_d;
  logic              rd_valid_q,   rd_valid_d;
  logic              rd_miss_q,    rd_miss_d;
  logic [MISS_W-1:0] miss_cnt_q,   miss_cnt_d;

  // Next-state: capture data on a mapped hit, keep old data on a miss, and
  // let a clear coinciding with a miss leave the count at one
  always_comb begin
    ram_ad_out_d = ram_ad_out_q;
    ram_out_d    = ram_out_q;
    rd_valid_d   = 1'b0;
    rd_miss_d    = 1'b0;
    miss_cnt_d   = miss_cnt_q;

    if (bus.RD_REQ) begin
      rd_valid_d   = 1'b1;
      ram_ad_out_d = bus.RAM_AD_IN;
      case (ad_cls)
        AD_RAM:  ram_out_d = ram_word;
        AD_IO:   ram_out_d = io_word;
        default: rd_miss_d = 1'b1;
      endcase
    end

    if (bus.MISS_CLR) begin
      miss_cnt_d = rd_miss_d ? MISS_W'(1) : '0;
    end else if (rd_miss_d && (miss_cnt_q != CNT_MAX)) begin
      miss_cnt_d = miss_cnt_q + MISS_W'(1);
    end
  end

  // Output registers; reset drops any request in flight
  always_ff @(posedge CLK_DC or posedge RESET) begin
    if (RESET) begin
      ram_ad_out_q <= '0;
      ram_out_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_miss_q    <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      ram_ad_out_q <= ram_ad_out_d;
      ram_out_q    <= ram_out_d;
      rd_valid_q   <= rd_valid_d;
      rd_miss_q    <= rd_miss_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bus.RAM_AD_OUT = ram_ad_out_q;
  assign bus.RAM_OUT    = ram_out_q;
  assign bus.RD_VALID   = rd_valid_q;
  assign bus.RD_MISS    = rd_miss_q;
  assign bus.MISS_CNT   = miss_cnt_q;

endmodule

// File: tb/tb_ram_rd_dc.sv
// Self-checking bench for ram_rd_dc: expected responses are queued when a
// request is accepted and a monitor compares them when RD_VALID shows up.
// Follows RAM_RD_DC_IO_SYNC_EN the same way the design does.
module tb_ram_rd_dc;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 8;
  localparam int RAM_DEPTH = 8;
  localparam int IO_NUM    = 2;
  localparam int IO_BASE   = 65;
  localparam int MISS_W    = 8;
  localparam int CNT_MAX   = (1 << MISS_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  ram_rd_dc_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH),
    .IO_NUM(IO_NUM), .MISS_W(MISS_W)
  ) bus ();

  ram_rd_dc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH),
    .IO_NUM(IO_NUM), .IO_BASE(IO_BASE), .MISS_W(MISS_W)
  ) dut (
    .CLK_DC(clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Contents the bench presents on RAM_FLAT / IO_IN
  logic [DATA_W-1:0] ram_mem [RAM_DEPTH];
  logic [DATA_W-1:0] io_mem  [IO_NUM];

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] ad;
    logic              miss;
    logic [MISS_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [DATA_W-1:0] m_data = '0;
  logic [ADDR_W-1:0] m_ad   = '0;
  int                m_cnt  = 0;
  logic [DATA_W-1:0] io_h1 [IO_NUM];
  logic [DATA_W-1:0] io_h2 [IO_NUM];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic packInputs();
    for (int i = 0; i < RAM_DEPTH; i++) bus.RAM_FLAT[i*DATA_W +: DATA_W] = ram_mem[i];
    for (int j = 0; j < IO_NUM; j++) bus.IO_IN[j*DATA_W +: DATA_W] = io_mem[j];
  endtask

  // Drive one cycle of stimulus; returns just after the edge that samples it
  task automatic applyStimulus(input logic req, input logic [ADDR_W-1:0] ad, input logic clr);
    packInputs();
    bus.RD_REQ    = req;
    bus.RAM_AD_IN = ad;
    bus.MISS_CLR  = clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: decides the response of every accepted request from the
  // memory map rules and queues it
  always @(posedge clk or posedge rst) begin
    logic [DATA_W-1:0] io_view [IO_NUM];
    int   a;
    logic miss;
    if (rst) begin
      m_data = '0;
      m_ad   = '0;
      m_cnt  = 0;
      exp_q.delete();
      for (int j = 0; j < IO_NUM; j++) begin
        io_h1[j] = '0;
        io_h2[j] = '0;
      end
    end else begin
`ifdef RAM_RD_DC_IO_SYNC_EN
      io_view = io_h2;
`else
      io_view = io_mem;
`endif
      miss = 1'b0;
      if (bus.RD_REQ) begin
        a = int'(bus.RAM_AD_IN);
        if (a < RAM_DEPTH) m_data = ram_mem[a];
        else if (a >= IO_BASE && a < IO_BASE + IO_NUM) m_data = io_view[a - IO_BASE];
        else miss = 1'b1;
        m_ad = bus.RAM_AD_IN;
      end
      if (bus.MISS_CLR) m_cnt = miss ? 1 : 0;
      else if (miss && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (bus.RD_REQ) exp_q.push_back('{m_data, m_ad, miss, MISS_W'(m_cnt)});
      io_h2 = io_h1;
      io_h1 = io_mem;
    end
  end

  // Monitor: a completion is expected exactly when the queue holds one;
  // otherwise the outputs must be idle and holding
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("rd_valid", 32'(bus.RD_VALID), 32'd1);
      checkOutput("ram_out", 32'(bus.RAM_OUT), 32'(e.data));
      checkOutput("ram_ad_out", 32'(bus.RAM_AD_OUT), 32'(e.ad));
      checkOutput("rd_miss", 32'(bus.RD_MISS), 32'(e.miss));
      checkOutput("miss_cnt", 32'(bus.MISS_CNT), 32'(e.cnt));
    end else begin
      checkOutput("rd_valid_idle", 32'(bus.RD_VALID), 32'd0);
      checkOutput("rd_miss_idle", 32'(bus.RD_MISS), 32'd0);
      checkOutput("ram_out_hold", 32'(bus.RAM_OUT), 32'(m_data));
      checkOutput("ram_ad_out_hold", 32'(bus.RAM_AD_OUT), 32'(m_ad));
      checkOutput("miss_cnt_idle", 32'(bus.MISS_CNT), 32'(m_cnt));
    end
  end

  logic [ADDR_W-1:0] edge_ads [8];
  logic [ADDR_W-1:0] seq5 [4];

  initial begin
    logic [ADDR_W-1:0] ad;
    int cat;
    for (int i = 0; i < RAM_DEPTH; i++) ram_mem[i] = DATA_W'(16'h1000 + i);
    for (int j = 0; j < IO_NUM; j++) io_mem[j] = DATA_W'(16'h2000 + j);
    edge_ads = '{8'd0, 8'd7, 8'd8, 8'd64, 8'd65, 8'd66, 8'd67, 8'd255};
    seq5     = '{8'd0, 8'd1, 8'd7, 8'd65};
    packInputs();
    bus.RD_REQ    = 1'b0;
    bus.RAM_AD_IN = '0;
    bus.MISS_CLR  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    $display("[TB] reset released");

    // RAM word 3
    ram_mem[3] = 16'h1234;
    applyStimulus(1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 8'd3, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);

    // Input port 1, then a port change on the request edge
    io_mem[1] = 16'hBEEF;
    repeat (3) applyStimulus(1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 8'd66, 1'b0);
    io_mem[1] = 16'hCAFE;
    applyStimulus(1'b1, 8'd66, 1'b0);
    applyStimulus(1'b1, 8'd66, 1'b0);
    applyStimulus(1'b1, 8'd66, 1'b0);

    // Unmapped read keeps the previous data
    applyStimulus(1'b1, 8'd3, 1'b0);
    applyStimulus(1'b1, 8'd20, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);

    // Saturation, then clear with and without a coincident miss
    for (int k = 0; k < 300; k++) applyStimulus(1'b1, 8'($urandom_range(67, 255)), 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 8'd100, 1'b1);
    applyStimulus(1'b1, 8'd9, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1);
    applyStimulus(1'b1, 8'd2, 1'b1);

    // Back-to-back requests
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, seq5[k], 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);

    // Reset in the middle of a cycle following a request edge
    applyStimulus(1'b1, 8'd20, 1'b0);
    applyStimulus(1'b1, 8'd5, 1'b0);
    bus.RD_REQ = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) applyStimulus(1'b0, 8'd0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) ram_mem[$urandom_range(0, RAM_DEPTH-1)] = DATA_W'($urandom);
      if ($urandom_range(0, 2) == 0) io_mem[$urandom_range(0, IO_NUM-1)] = DATA_W'($urandom);
      cat = $urandom_range(0, 3);
      case (cat)
        0: ad = 8'($urandom_range(0, RAM_DEPTH-1));
        1: ad = 8'($urandom_range(IO_BASE, IO_BASE + IO_NUM - 1));
        2: begin
          ad = 8'($urandom_range(RAM_DEPTH, 255));
          if (ad == 8'd65 || ad == 8'd66) ad = 8'd30;
        end
        default: ad = edge_ads[$urandom_range(0, 7)];
      endcase
      applyStimulus(1'($urandom_range(0, 3) != 0), ad, 1'($urandom_range(0, 15) == 0));
    end

    repeat (3) applyStimulus(1'b0, 8'd0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
